// File: rtl/bcd_time_converter_pkg.sv
// Shared constants for the elapsed-time BCD path: digit geometry, add-3 rule
// and the default widths used by the timer manager and seven-segment driver.
package bcd_time_converter_pkg;

    localparam int          DEF_BIN_W   = 13;
    localparam int          DEF_DIGITS  = 4;
    localparam int          DEF_MAX_VAL = 9999;

    localparam int          BCD_DIGIT_W = 4;
    localparam logic [3:0]  ADD3_THRESH = 4'd5;
    localparam logic [3:0]  ADD3_VAL    = 4'd3;
    localparam logic [15:0] BCD_NINES   = 16'h9999;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_time_converter_if.sv
// Start/done handshake plus result bus between a requester and the converter.
interface bcd_time_converter_if
    import bcd_time_converter_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS
);
    logic                          start;
    logic [BIN_W-1:0]              bin_in;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic                          overflow;

    modport master (
        output start, bin_in,
        input  busy, done, bcd_out, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, bcd_out, overflow
    );
endinterface

// File: rtl/bcd_add3_cell.sv
// Double-dabble nibble corrector: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_cell
    import bcd_time_converter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] nib_i,
    output logic [BCD_DIGIT_W-1:0] nib_o
);
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= ADD3_THRESH) begin
            nib_o = nib_i + ADD3_VAL;
        end
    end
endmodule

// File: rtl/bcd_time_converter.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per cycle. The last
// completed result is held on bcd_out/overflow until the next done edge.
module bcd_time_converter
    import bcd_time_converter_pkg::*;
#(
    parameter int BIN_W   = DEF_BIN_W,
    parameter int DIGITS  = DEF_DIGITS,
    parameter int MAX_VAL = DEF_MAX_VAL
)(
    input  logic                 clk,
    input  logic                 reset_n,
    bcd_time_converter_if.slave  conv_if
);
    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [BIN_W-1:0]   shift_q,   shift_d;
    logic [SCR_W-1:0]   scratch_q, scratch_d;
    logic               sat_q,     sat_d;
    logic [SCR_W-1:0]   bcd_q,     bcd_d;
    logic               ovf_q,     ovf_d;
    logic               done_q,    done_d;

    logic [SCR_W-1:0]   corr;
    logic [SCR_W-1:0]   nines;

    assign nines = {DIGITS{BCD_NINES[BCD_DIGIT_W-1:0]}};

    // All digits are corrected in parallel, ahead of the shift in the same cycle.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3_cell u_cell (
                .nib_i (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .nib_o (corr[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            scratch_q <= '0;
            sat_q     <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            sat_q     <= sat_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        sat_d     = sat_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (conv_if.start) begin
                    shift_d   = conv_if.bin_in;
                    scratch_d = '0;
                    sat_d     = {1'b0, conv_if.bin_in} > (BIN_W + 1)'(MAX_VAL);
                    count_d   = CNT_W'(BIN_W);
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                {scratch_d, shift_d} = {corr, shift_q} << 1;
                count_d = count_q - CNT_W'(1);
                // The last shift lands directly on the held result registers.
                if (count_q == CNT_W'(1)) begin
                    bcd_d   = sat_q ? nines : scratch_d;
                    ovf_d   = sat_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign conv_if.busy     = (state_q == CONVERT);
    assign conv_if.done     = done_q;
    assign conv_if.bcd_out  = bcd_q;
    assign conv_if.overflow = ovf_q;

endmodule

// File: tb/tb_bcd_time_converter.sv
// Directed bench for two converter instances (13-bit and 14-bit input) with a
// transaction-level reference model checked on every falling edge.
module tb_bcd_time_converter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bcd_time_converter_if #(.BIN_W(13), .DIGITS(4)) bus13 ();
    bcd_time_converter_if #(.BIN_W(14), .DIGITS(4)) bus14 ();

    bcd_time_converter #(.BIN_W(13), .DIGITS(4), .MAX_VAL(9999)) dut13 (
        .clk(clk), .reset_n(reset_n), .conv_if(bus13)
    );
    bcd_time_converter #(.BIN_W(14), .DIGITS(4), .MAX_VAL(9999)) dut14 (
        .clk(clk), .reset_n(reset_n), .conv_if(bus14)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Decimal digits straight from division; saturates above the display range.
    function automatic logic [15:0] exp_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Reference model: a request accepted while idle completes LAT edges later.
    int          m_cnt  [2];
    int          m_val  [2];
    bit          m_done [2];
    logic [15:0] m_bcd  [2];
    bit          m_ovf  [2];
    int          lat_of [2] = '{13, 14};

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_cnt[k] = 0; m_done[k] = 0; m_bcd[k] = 16'h0; m_ovf[k] = 0; m_val[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_cnt[k] > 0) begin
                    m_cnt[k]--;
                    if (m_cnt[k] == 0) begin
                        m_done[k] = 1;
                        m_bcd[k]  = exp_bcd(m_val[k]);
                        m_ovf[k]  = (m_val[k] > 9999);
                    end
                end else if ((k == 0) ? bus13.start : bus14.start) begin
                    m_val[k] = (k == 0) ? int'(bus13.bin_in) : int'(bus14.bin_in);
                    m_cnt[k] = lat_of[k];
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m13_busy", 32'(bus13.busy),     32'(m_cnt[0] > 0));
        check("m13_done", 32'(bus13.done),     32'(m_done[0]));
        check("m13_bcd",  32'(bus13.bcd_out),  32'(m_bcd[0]));
        check("m13_ovf",  32'(bus13.overflow), 32'(m_ovf[0]));
        check("m14_busy", 32'(bus14.busy),     32'(m_cnt[1] > 0));
        check("m14_done", 32'(bus14.done),     32'(m_done[1]));
        check("m14_bcd",  32'(bus14.bcd_out),  32'(m_bcd[1]));
        check("m14_ovf",  32'(bus14.overflow), 32'(m_ovf[1]));
    end

    task automatic drive(input int k, input logic s, input int v);
        if (k == 0) begin bus13.start = s; bus13.bin_in = 13'(v); end
        else        begin bus14.start = s; bus14.bin_in = 14'(v); end
    endtask

    // Called just after a falling edge; returns on the falling edge that shows done.
    task automatic run(input int k, input int v, input int poke_at, input int poke_v,
                       output int busy_cnt, output int lat);
        logic b, d;
        drive(k, 1'b1, v);
        busy_cnt = 0;
        lat = 0;
        d = 1'b0;
        while (lat < 40 && !d) begin
            @(negedge clk);
            lat++;
            drive(k, 1'b0, v);
            b = (k == 0) ? bus13.busy : bus14.busy;
            d = (k == 0) ? bus13.done : bus14.done;
            if (b) busy_cnt++;
            if (b && poke_at != 0 && busy_cnt == poke_at) drive(k, 1'b1, poke_v);
        end
        if (!d) check("done_timeout", 32'(lat), 32'(lat_of[k] + 1));
    endtask

    task automatic run_check(input string name, input int k, input int v,
                             input logic [15:0] want_bcd, input logic want_ovf);
        int bc, lt;
        run(k, v, 0, 0, bc, lt);
        check({name, "_bcd"},  32'((k == 0) ? bus13.bcd_out : bus14.bcd_out), 32'(want_bcd));
        check({name, "_ovf"},  32'((k == 0) ? bus13.overflow : bus14.overflow), 32'(want_ovf));
        check({name, "_lat"},  32'(lt), 32'(lat_of[k] + 1));
        check({name, "_busy"}, 32'(bc), 32'(lat_of[k]));
        $display("[TB] inst%0d bin_in=%0d -> bcd_out=%04h overflow=%0b latency=%0d",
                 k == 0 ? 13 : 14, v,
                 (k == 0) ? bus13.bcd_out : bus14.bcd_out,
                 (k == 0) ? bus13.overflow : bus14.overflow, lt);
    endtask

    initial begin
        int bc, lt, extra;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus13.busy), 32'd0);
        check("rst_done", 32'(bus13.done), 32'd0);
        check("rst_bcd",  32'(bus13.bcd_out), 32'h0);
        check("rst_ovf",  32'(bus13.overflow), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_check("zero",  0, 0,    16'h0000, 1'b0);
        run_check("v1234", 0, 1234, 16'h1234, 1'b0);
        run_check("v8191", 0, 8191, 16'h8191, 1'b0);
        run_check("v9",    0, 9,    16'h0009, 1'b0);
        run_check("v10",   0, 10,   16'h0010, 1'b0);

        // A start pulse in the middle of a conversion must be ignored.
        run(0, 1111, 5, 42, bc, lt);
        check("ignore_bcd", 32'(bus13.bcd_out), 32'h1111);
        check("ignore_lat", 32'(lt), 32'd14);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus13.done) extra++;
        end
        check("ignore_extra_done", 32'(extra), 32'd0);
        $display("[TB] inst13 bin_in=1111 with start(42) at busy cycle 5 -> %04h", bus13.bcd_out);

        // Back-to-back: start issued in the done cycle is accepted.
        run(0, 777, 0, 0, bc, lt);
        run(0, 250, 0, 0, bc, lt);
        check("b2b_bcd", 32'(bus13.bcd_out), 32'h0250);
        check("b2b_lat", 32'(lt), 32'd14);
        $display("[TB] inst13 back-to-back bin_in=250 -> %04h latency=%0d", bus13.bcd_out, lt);

        // Asynchronous reset mid-conversion.
        drive(0, 1'b1, 5000);
        @(negedge clk);
        drive(0, 1'b0, 5000);
        repeat (6) @(negedge clk);
        check("pre_rst_busy", 32'(bus13.busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus13.busy), 32'd0);
        check("arst_done", 32'(bus13.done), 32'd0);
        check("arst_bcd",  32'(bus13.bcd_out), 32'h0);
        $display("[TB] inst13 async reset during 5000 -> busy=%0b bcd_out=%04h", bus13.busy, bus13.bcd_out);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_check("v5000", 0, 5000, 16'h5000, 1'b0);

        run_check("w12000", 1, 12000, 16'h9999, 1'b1);
        run_check("w9999",  1, 9999,  16'h9999, 1'b0);
        run_check("w10000", 1, 10000, 16'h9999, 1'b1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
